// File: rtl/store_buffer.sv
// Store buffer: holds executed stores in program order until ROB commit,
// drains committed stores to the DCache and forwards data to younger loads.
module store_buffer #(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned ROB_INDEX_BITS = 3,
  parameter int unsigned MICROOP_WIDTH  = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      store_valid,
  input  logic [31:0]               store_address,
  input  logic [31:0]               store_data,
  input  logic [MICROOP_WIDTH-1:0]  store_microop,
  input  logic [ROB_INDEX_BITS-1:0] store_ticket,
  output logic                      full,
  output logic                      empty,
  input  logic                      commit_valid,
  input  logic [ROB_INDEX_BITS-1:0] commit_ticket,
  input  logic                      flush,
  input  logic [31:0]               frw_address,
  input  logic [MICROOP_WIDTH-1:0]  frw_microop,
  output logic [31:0]               frw_data,
  output logic                      frw_valid,
  output logic                      frw_stall,
  output logic                      cache_wr_valid,
  output logic [31:0]               cache_wr_addr,
  output logic [31:0]               cache_wr_data,
  output logic [MICROOP_WIDTH-1:0]  cache_wr_microop,
  input  logic                      cache_wr_ready,
  output logic                      cache_writeback_valid
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DEPTH-1:0]          valid_q, valid_d;
  logic [DEPTH-1:0]          cmt_q, cmt_d;
  logic [31:0]               addr_q [DEPTH];
  logic [31:0]               addr_d [DEPTH];
  logic [31:0]               data_q [DEPTH];
  logic [31:0]               data_d [DEPTH];
  logic [MICROOP_WIDTH-1:0]  uop_q  [DEPTH];
  logic [MICROOP_WIDTH-1:0]  uop_d  [DEPTH];
  logic [ROB_INDEX_BITS-1:0] tkt_q  [DEPTH];
  logic [ROB_INDEX_BITS-1:0] tkt_d  [DEPTH];
  logic [PW-1:0]             head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]             count_q, count_d;
  logic                      wb_q, wb_d;

  logic                      drain, enq;
  logic [CW-1:0]             ncmt;

  logic [PW-1:0]             idx;
  logic [2:0]                e_lo, e_hi, f_lo, f_hi;
  logic                      f_hit, f_exact;
  logic [31:0]               f_data;
  logic                      frw_uop_unused;

  function automatic logic [2:0] nbytes(input logic [1:0] sz);
    case (sz)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
  endfunction

  assign full             = (count_q == CW'(DEPTH));
  assign empty            = (count_q == '0);
  assign cache_wr_valid   = valid_q[head_q] && cmt_q[head_q];
  assign cache_wr_addr    = addr_q[head_q];
  assign cache_wr_data    = data_q[head_q];
  assign cache_wr_microop = uop_q[head_q];
  assign cache_writeback_valid = wb_q;

  assign drain = cache_wr_valid && cache_wr_ready;
  assign enq   = store_valid && !full && !flush;

  always_comb begin
    valid_d = valid_q;
    cmt_d   = cmt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    uop_d   = uop_q;
    tkt_d   = tkt_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ncmt    = '0;
    wb_d    = drain;

    if (commit_valid) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && !cmt_q[i] && (tkt_q[i] == commit_ticket)) cmt_d[i] = 1'b1;
      end
    end

    // Committed count includes this cycle's commit so a same-cycle flush keeps it.
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && cmt_d[i]) ncmt = ncmt + CW'(1);
    end

    if (drain) begin
      valid_d[head_q] = 1'b0;
      cmt_d[head_q]   = 1'b0;
      head_d          = head_q + PW'(1);
    end

    if (flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && !cmt_d[i]) valid_d[i] = 1'b0;
      end
      tail_d  = head_q + ncmt[PW-1:0];
      count_d = ncmt - CW'(drain);
    end else begin
      if (enq) begin
        valid_d[tail_q] = 1'b1;
        cmt_d[tail_q]   = 1'b0;
        addr_d[tail_q]  = store_address;
        data_d[tail_q]  = store_data;
        uop_d[tail_q]   = store_microop;
        tkt_d[tail_q]   = store_ticket;
        tail_d          = tail_q + PW'(1);
      end
      count_d = count_q + CW'(enq) - CW'(drain);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      cmt_q   <= '0;
      addr_q  <= '{default: '0};
      data_q  <= '{default: '0};
      uop_q   <= '{default: '0};
      tkt_q   <= '{default: '0};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      wb_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      cmt_q   <= cmt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      uop_q   <= uop_d;
      tkt_q   <= tkt_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      wb_q    <= wb_d;
    end
  end

  // Only the size field of the load microop matters for forwarding.
  assign frw_uop_unused = ^frw_microop;
  assign f_lo = {1'b0, frw_address[1:0]};
  assign f_hi = f_lo + nbytes(frw_microop[1:0]) - 3'd1;

  // Valid entries are contiguous from head, so scanning oldest to youngest
  // and letting later hits overwrite leaves the youngest overlap.
  always_comb begin
    f_hit   = 1'b0;
    f_exact = 1'b0;
    f_data  = '0;
    idx     = '0;
    e_lo    = '0;
    e_hi    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx  = head_q + PW'(i);
      e_lo = {1'b0, addr_q[idx][1:0]};
      e_hi = e_lo + nbytes(uop_q[idx][1:0]) - 3'd1;
      if (valid_q[idx] && (addr_q[idx][31:2] == frw_address[31:2]) &&
          (e_lo <= f_hi) && (f_lo <= e_hi)) begin
        f_hit   = 1'b1;
        f_exact = (addr_q[idx] == frw_address) && (uop_q[idx][1:0] == frw_microop[1:0]);
        f_data  = data_q[idx];
      end
    end
  end

  assign frw_valid = f_hit && f_exact;
  assign frw_stall = f_hit && !f_exact;
  assign frw_data  = frw_valid ? f_data : '0;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus a randomized
// phase, all checked against a queue-based behavioural model.
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam logic [4:0] UB = 5'b00000, UH = 5'b00001, UW = 5'b00010;

  logic        clk = 1'b0;
  logic        rst;
  logic        store_valid;
  logic [31:0] store_address, store_data;
  logic [4:0]  store_microop;
  logic [2:0]  store_ticket;
  logic        full, empty;
  logic        commit_valid;
  logic [2:0]  commit_ticket;
  logic        flush;
  logic [31:0] frw_address, frw_data;
  logic [4:0]  frw_microop;
  logic        frw_valid, frw_stall;
  logic        cache_wr_valid;
  logic [31:0] cache_wr_addr, cache_wr_data;
  logic [4:0]  cache_wr_microop;
  logic        cache_wr_ready;
  logic        cache_writeback_valid;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH), .ROB_INDEX_BITS(3), .MICROOP_WIDTH(5)) dut (
    .clk(clk), .rst(rst),
    .store_valid(store_valid), .store_address(store_address), .store_data(store_data),
    .store_microop(store_microop), .store_ticket(store_ticket),
    .full(full), .empty(empty),
    .commit_valid(commit_valid), .commit_ticket(commit_ticket), .flush(flush),
    .frw_address(frw_address), .frw_microop(frw_microop),
    .frw_data(frw_data), .frw_valid(frw_valid), .frw_stall(frw_stall),
    .cache_wr_valid(cache_wr_valid), .cache_wr_addr(cache_wr_addr),
    .cache_wr_data(cache_wr_data), .cache_wr_microop(cache_wr_microop),
    .cache_wr_ready(cache_wr_ready), .cache_writeback_valid(cache_writeback_valid)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [4:0]  uop;
    logic [2:0]  tkt;
    bit          cm;
  } ent_t;

  ent_t        q[$];
  bit          exp_wb;
  int          total = 0;
  int          bad = 0;
  logic [31:0] drained[$];
  int          wb_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int nb(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  function automatic void model_frw(output bit v, output bit st, output logic [31:0] d);
    int alo, ahi, blo, bhi;
    v = 0; st = 0; d = '0;
    blo = int'(frw_address[1:0]);
    bhi = blo + nb(frw_microop[1:0]) - 1;
    for (int k = q.size() - 1; k >= 0; k--) begin
      alo = int'(q[k].addr[1:0]);
      ahi = alo + nb(q[k].uop[1:0]) - 1;
      if (q[k].addr[31:2] == frw_address[31:2] && alo <= bhi && blo <= ahi) begin
        if (q[k].addr == frw_address && q[k].uop[1:0] == frw_microop[1:0]) begin
          v = 1; d = q[k].data;
        end else st = 1;
        return;
      end
    end
  endfunction

  task automatic check_outputs();
    bit v, st, cwv;
    logic [31:0] d;
    chk("full", full, q.size() == DEPTH);
    chk("empty", empty, q.size() == 0);
    cwv = 0;
    if (q.size() > 0) cwv = q[0].cm;
    chk("cwr_valid", cache_wr_valid, cwv);
    if (cwv) begin
      chk("cwr_addr", cache_wr_addr, q[0].addr);
      chk("cwr_data", cache_wr_data, q[0].data);
      chk("cwr_uop", cache_wr_microop, q[0].uop);
    end
    chk("wb_pulse", cache_writeback_valid, exp_wb);
    model_frw(v, st, d);
    chk("frw_valid", frw_valid, v);
    chk("frw_stall", frw_stall, st);
    if (!st) chk("frw_data", frw_data, d);
  endtask

  task automatic model_update();
    bit drn, full_pre;
    full_pre = (q.size() == DEPTH);
    drn = 0;
    if (q.size() > 0) drn = q[0].cm && cache_wr_ready;
    if (commit_valid) begin
      for (int k = 0; k < q.size(); k++) begin
        if (!q[k].cm && q[k].tkt == commit_ticket) begin
          q[k].cm = 1;
          break;
        end
      end
    end
    if (flush) while (q.size() > 0 && !q[q.size()-1].cm) void'(q.pop_back());
    if (drn) void'(q.pop_front());
    if (store_valid && !full_pre && !flush)
      q.push_back('{addr: store_address, data: store_data, uop: store_microop,
                    tkt: store_ticket, cm: 1'b0});
    exp_wb = drn;
  endtask

  task automatic tick();
    @(negedge clk);
    check_outputs();
    if (cache_wr_valid && cache_wr_ready) drained.push_back(cache_wr_addr);
    if (cache_writeback_valid) wb_seen++;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    store_valid = 0; store_address = '0; store_data = '0; store_microop = '0; store_ticket = '0;
    commit_valid = 0; commit_ticket = '0; flush = 0; cache_wr_ready = 0;
  endtask

  task automatic set_store(input logic [31:0] a, input logic [31:0] d, input logic [4:0] u,
                           input logic [2:0] t);
    store_valid = 1; store_address = a; store_data = d; store_microop = u; store_ticket = t;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_cwv"}, cache_wr_valid, 0);
    chk({tag, "_cwaddr"}, cache_wr_addr, 0);
    chk({tag, "_cwdata"}, cache_wr_data, 0);
    chk({tag, "_cwuop"}, cache_wr_microop, 0);
    chk({tag, "_wb"}, cache_writeback_valid, 0);
    chk({tag, "_fv"}, frw_valid, 0);
    chk({tag, "_fs"}, frw_stall, 0);
    chk({tag, "_fd"}, frw_data, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  nt;
    int          sz, fsz;
    logic [31:0] a;
    bit          found;
    idle();
    rst = 1; frw_address = '0; frw_microop = '0;
    exp_wb = 0; wb_seen = 0;
    #12;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 0;

    // Basic in-order commit and drain
    for (int i = 0; i < 3; i++) begin
      set_store(32'h100 + 32'(4*i), 32'hA0 + 32'(i), UW, 3'(i + 1));
      tick();
    end
    store_valid = 0;
    drained.delete(); wb_seen = 0;
    cache_wr_ready = 1;
    for (int i = 0; i < 3; i++) begin
      commit_valid = 1; commit_ticket = 3'(i + 1);
      tick();
    end
    commit_valid = 0;
    repeat (4) tick();
    chk("t1_ndrain", drained.size(), 3);
    if (drained.size() == 3)
      for (int i = 0; i < 3; i++) chk("t1_order", drained[i], 32'h100 + 32'(4*i));
    chk("t1_wbcount", wb_seen, 3);
    chk("t1_empty", empty, 1);

    // Fill then overflow attempt
    cache_wr_ready = 0;
    for (int i = 0; i < 4; i++) begin
      set_store(32'h180 + 32'(4*i), 32'(i), UW, 3'(4 + i));
      tick();
    end
    chk("t2_full", full, 1);
    set_store(32'h190, 32'h55, UW, 3'd0);
    tick();
    store_valid = 0;
    chk("t2_full_after_drop", full, 1);
    flush = 1; tick(); flush = 0;
    chk("t2_empty_after_flush", empty, 1);

    // Forwarding: youngest hit, partial overlap, miss
    set_store(32'h200, 32'hDEADBEEF, UW, 3'd1); tick();
    set_store(32'h200, 32'h11111111, UW, 3'd2); tick();
    store_valid = 0;
    frw_address = 32'h200; frw_microop = UW; #1;
    chk("t3_lw_valid", frw_valid, 1);
    chk("t3_lw_data", frw_data, 32'h11111111);
    chk("t3_lw_stall", frw_stall, 0);
    frw_address = 32'h201; frw_microop = UB; #1;
    chk("t3_lb_stall", frw_stall, 1);
    chk("t3_lb_valid", frw_valid, 0);
    frw_address = 32'h300; frw_microop = UW; #1;
    chk("t3_miss_valid", frw_valid, 0);
    chk("t3_miss_stall", frw_stall, 0);
    chk("t3_miss_data", frw_data, 0);
    tick();
    flush = 1; tick(); flush = 0;

    // Commit together with flush keeps the committed store
    cache_wr_ready = 0;
    for (int i = 0; i < 3; i++) begin
      set_store(32'h400 + 32'(4*i), 32'hB0 + 32'(i), UW, 3'(4 + i));
      tick();
    end
    store_valid = 0;
    commit_valid = 1; commit_ticket = 3'd4; flush = 1;
    tick();
    commit_valid = 0; flush = 0;
    chk("t4_empty", empty, 0);
    chk("t4_full", full, 0);
    chk("t4_cwv", cache_wr_valid, 1);
    chk("t4_cwaddr", cache_wr_addr, 32'h400);
    frw_address = 32'h404; frw_microop = UW; #1;
    chk("t4_frw5", frw_valid | frw_stall, 0);
    frw_address = 32'h408; #1;
    chk("t4_frw6", frw_valid | frw_stall, 0);
    set_store(32'h480, 32'hC0, UW, 3'd1); tick();
    set_store(32'h484, 32'hC1, UW, 3'd2); tick();
    chk("t4_notfull", full, 0);
    set_store(32'h488, 32'hC2, UW, 3'd3); tick();
    store_valid = 0;
    chk("t4_full_count1", full, 1);
    drained.delete();
    cache_wr_ready = 1;
    for (int i = 1; i <= 3; i++) begin
      commit_valid = 1; commit_ticket = 3'(i);
      tick();
    end
    commit_valid = 0;
    repeat (3) tick();
    chk("t4_ndrain", drained.size(), 4);
    if (drained.size() > 0) chk("t4_first", drained[0], 32'h400);

    // Stall under back-pressure then a single writeback pulse
    cache_wr_ready = 0;
    set_store(32'h500, 32'hCAFEF00D, UW, 3'd5); tick();
    store_valid = 0;
    commit_valid = 1; commit_ticket = 3'd5; tick();
    commit_valid = 0;
    wb_seen = 0;
    for (int i = 0; i < 5; i++) begin
      chk("t5_cwv_hold", cache_wr_valid, 1);
      chk("t5_addr_hold", cache_wr_addr, 32'h500);
      chk("t5_data_hold", cache_wr_data, 32'hCAFEF00D);
      tick();
    end
    cache_wr_ready = 1; tick();
    cache_wr_ready = 0;
    repeat (3) tick();
    chk("t5_one_pulse", wb_seen, 1);

    // Wrap-around with pipelined store/commit/drain
    cache_wr_ready = 1;
    drained.delete();
    for (int i = 0; i < 12; i++) begin
      if (i < 10) set_store(32'h600 + 32'(4*i), 32'(i), UW, 3'(i));
      else store_valid = 0;
      commit_valid = (i >= 1 && i <= 10);
      commit_ticket = 3'(i - 1);
      tick();
    end
    idle();
    cache_wr_ready = 1;
    repeat (4) tick();
    chk("wrap_ndrain", drained.size(), 10);
    if (drained.size() == 10)
      for (int i = 0; i < 10; i++) chk("wrap_order", drained[i], 32'h600 + 32'(4*i));

    // Randomized traffic against the model
    nt = 3'd0;
    for (int n = 0; n < 400; n++) begin
      idle();
      flush = ($urandom_range(0, 99) < 4);
      cache_wr_ready = ($urandom_range(0, 99) < 70);
      if ($urandom_range(0, 99) < 55) begin
        sz = $urandom_range(0, 2);
        a = 32'h700 + 32'(4 * $urandom_range(0, 3));
        if (sz == 1) a = a + 32'(2 * $urandom_range(0, 1));
        if (sz == 0) a = a + 32'($urandom_range(0, 3));
        set_store(a, $urandom, {3'($urandom), 2'(sz)}, nt);
        if (q.size() < DEPTH && !flush) nt = nt + 3'd1;
      end
      found = 0;
      for (int k = 0; k < q.size(); k++)
        if (!found && !q[k].cm) begin found = 1; commit_ticket = q[k].tkt; end
      if (found && $urandom_range(0, 99) < 50) commit_valid = 1;
      else if ($urandom_range(0, 99) < 5) begin
        for (int t = 0; t < 8; t++) begin
          found = 0;
          for (int k = 0; k < q.size(); k++) if (!q[k].cm && q[k].tkt == 3'(t)) found = 1;
          if (!found) commit_ticket = 3'(t);
        end
        commit_valid = 1;
      end
      fsz = $urandom_range(0, 2);
      a = 32'h700 + 32'(4 * $urandom_range(0, 3));
      if (fsz == 1) a = a + 32'(2 * $urandom_range(0, 1));
      if (fsz == 0) a = a + 32'($urandom_range(0, 3));
      frw_address = a; frw_microop = {3'($urandom), 2'(fsz)};
      tick();
    end

    // Asynchronous reset mid-operation
    idle();
    set_store(32'h800, 32'h12345678, UW, 3'd2); tick();
    store_valid = 0;
    commit_valid = 1; commit_ticket = 3'd2; tick();
    commit_valid = 0;
    set_store(32'h804, 32'h9, UW, 3'd3); tick();
    idle();
    frw_address = 32'h800; frw_microop = UW;
    rst = 1; #2;
    check_reset_outputs("midrst");
    q.delete(); exp_wb = 0;
    #1 rst = 0;
    cache_wr_ready = 1;
    tick();
    set_store(32'h900, 32'h77, UW, 3'd4); tick();
    store_valid = 0;
    commit_valid = 1; commit_ticket = 3'd4; tick();
    commit_valid = 0;
    repeat (3) tick();
    chk("post_rst_empty", empty, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
